// File: rtl/proc_prog_feeder.sv
`default_nettype none
// =============================================================================
// Module   : proc_prog_feeder
// Purpose  : Replays a loaded program into the 9-bit multi-cycle processor,
//            pacing each instruction on Done and flagging hangs/bad programs.
// Revision : 1.0
// =============================================================================
module proc_prog_feeder #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              Start,
  input  logic              Done,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [ADDR_W:0]   PC,
  output logic [7:0]        InstrCount
);

  localparam int                c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
  localparam logic [2:0]        c_OP_MVI   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_W-1:0]    r_ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W:0]      r_pc;
  logic [ADDR_W:0]      r_len;
  logic [7:0]           r_count;
  logic [c_TMO_W-1:0]   r_tmo;

  logic [DATA_W-1:0]    w_word;
  logic [ADDR_W:0]      w_pc_inc;
  logic                 w_is_mvi;
  logic                 w_idle_like;
  logic                 w_busy;
  logic                 w_complete;

  assign w_word      = r_ram[r_pc[ADDR_W-1:0]];
  assign w_pc_inc    = r_pc + 1'b1;
  assign w_is_mvi    = (w_word[DATA_W-1 -: 3] == c_OP_MVI);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERROR);
  assign w_busy      = (r_state == S_ISSUE) || (r_state == S_IMM) || (r_state == S_WAIT);

  // Program RAM is never cleared by reset; loads are locked out while running.
  always_ff @(posedge Clock) begin
    if (LoadEn && !w_busy) begin
      r_ram[LoadAddr] <= LoadData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          w_state_nxt = (ProgLen == '0) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_is_mvi) begin
          // The immediate must live inside the program, otherwise it is malformed.
          w_state_nxt = (w_pc_inc == r_len) ? S_ERROR : S_IMM;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_IMM: begin
        if (Done) begin
          w_complete  = 1'b1;
          w_state_nxt = (w_pc_inc == r_len) ? S_HALT : S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Done) begin
          w_complete  = 1'b1;
          w_state_nxt = (r_pc == r_len) ? S_HALT : S_ISSUE;
        end else if (r_tmo == c_TMO_LAST) begin
          w_state_nxt = S_ERROR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc    <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (Start) begin
            r_len   <= ProgLen;
            r_pc    <= '0;
            r_count <= '0;
          end
        end
        S_ISSUE: begin
          r_pc  <= w_pc_inc;
          r_tmo <= '0;
        end
        S_IMM:   r_pc  <= w_pc_inc;
        S_WAIT:  r_tmo <= r_tmo + 1'b1;
        default: ;
      endcase
      if (w_complete && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_comb begin
    DIN = '0;
    if ((r_state == S_ISSUE) || (r_state == S_IMM)) begin
      DIN = w_word;
    end
  end

  assign Run        = (r_state == S_ISSUE);
  assign Busy       = w_busy;
  assign Halted     = (r_state == S_HALT);
  assign Err        = (r_state == S_ERROR);
  assign PC         = r_pc;
  assign InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_proc_prog_feeder.sv
`default_nettype none
// =============================================================================
// Module   : tb_proc_prog_feeder
// Purpose  : Directed table-driven bench plus a full-length program sequence.
// Revision : 1.0
// =============================================================================
module tb_proc_prog_feeder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       LoadEn = 1'b0;
  logic [4:0] LoadAddr = '0;
  logic [8:0] LoadData = '0;
  logic [5:0] ProgLen = '0;
  logic       Start = 1'b0;
  logic       Done = 1'b0;
  logic [8:0] DIN;
  logic       Run;
  logic       Busy;
  logic       Halted;
  logic       Err;
  logic [5:0] PC;
  logic [7:0] InstrCount;

  int n_err = 0;
  int n_chk = 0;
  logic mon_en = 1'b0;
  logic prev_run = 1'b0;

  proc_prog_feeder #(.ADDR_W(5), .DATA_W(9), .TIMEOUT(7)) dut (
    .Clock(Clock), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .ProgLen(ProgLen), .Start(Start), .Done(Done),
    .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted), .Err(Err),
    .PC(PC), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst, ld;
    logic [4:0] la;
    logic [8:0] ldd;
    logic [5:0] plen;
    logic       st, dn, chk;
    logic [8:0] din;
    logic       run, busy, halt, err;
    logic [5:0] pc;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t v(logic rst, logic ld, logic [4:0] la, logic [8:0] ldd,
                             logic [5:0] plen, logic st, logic dn, logic chk,
                             logic [8:0] din, logic run, logic busy, logic halt,
                             logic err, logic [5:0] pc, logic [7:0] cnt);
    vec_t r;
    r.rst = rst; r.ld = ld; r.la = la; r.ldd = ldd; r.plen = plen; r.st = st;
    r.dn = dn; r.chk = chk; r.din = din; r.run = run; r.busy = busy;
    r.halt = halt; r.err = err; r.pc = pc; r.cnt = cnt;
    return r;
  endfunction

  // Run must never be high on two consecutive cycles.
  always @(negedge Clock) begin
    if (mon_en) begin
      n_chk++;
      if (Run && prev_run) begin
        n_err++;
        $display("FAIL run_back_to_back t=%0t got Run=1 twice, required single pulse", $time);
      end
    end
    prev_run = Run;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [8:0] exp_word;
    logic       run_seen;
    int         runs;
    bit         reached;

    // rst ld la ldd plen st dn | chk din run busy halt err pc cnt
    tbl.push_back(v(1,0,0,9'h000,0,0,0, 0,9'h000,0,0,0,0,0,0));  // 0 reset
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,0,0,0,0,0));  // 1 reset values
    tbl.push_back(v(0,1,0,9'h00A,0,0,0, 1,9'h000,0,0,0,0,0,0));  // 2 load mv
    tbl.push_back(v(0,0,0,9'h000,1,1,0, 1,9'h000,0,0,0,0,0,0));  // 3 start len1
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h00A,1,1,0,0,0,0));  // 4 issue mv
    tbl.push_back(v(0,0,0,9'h000,0,0,1, 1,9'h000,0,1,0,0,1,0));  // 5 wait, Done
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,0,1,0,1,1));  // 6 halted
    tbl.push_back(v(0,1,0,9'h040,0,0,0, 1,9'h000,0,0,1,0,1,1));  // 7 load mvi
    tbl.push_back(v(0,1,1,9'h055,0,0,0, 1,9'h000,0,0,1,0,1,1));  // 8 load imm
    tbl.push_back(v(0,1,2,9'h081,0,0,0, 1,9'h000,0,0,1,0,1,1));  // 9 load add
    tbl.push_back(v(0,0,0,9'h000,3,1,0, 1,9'h000,0,0,1,0,1,1));  // 10 start len3
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h040,1,1,0,0,0,0));  // 11 issue mvi
    tbl.push_back(v(0,0,0,9'h000,0,0,1, 1,9'h055,0,1,0,0,1,0));  // 12 imm, Done T1
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h081,1,1,0,0,2,1));  // 13 issue add back-to-back
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,1,0,0,3,1));  // 14 wait T1
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,1,0,0,3,1));  // 15 wait T2
    tbl.push_back(v(0,0,0,9'h000,0,0,1, 1,9'h000,0,1,0,0,3,1));  // 16 wait T3 Done
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,0,1,0,3,2));  // 17 halted
    tbl.push_back(v(0,1,0,9'h0C1,0,0,0, 1,9'h000,0,0,1,0,3,2));  // 18 load sub
    tbl.push_back(v(0,0,0,9'h000,1,1,0, 1,9'h000,0,0,1,0,3,2));  // 19 start len1
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h0C1,1,1,0,0,0,0));  // 20 issue sub
    for (int i = 0; i < 7; i++)                                  // 21..27 seven waits
      tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,1,0,0,1,0));
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,0,0,1,1,0));  // 28 timeout error
    tbl.push_back(v(0,0,0,9'h000,0,0,1, 1,9'h000,0,0,0,1,1,0));  // 29 Err holds, Done ignored
    tbl.push_back(v(0,1,0,9'h058,0,0,0, 1,9'h000,0,0,0,1,1,0));  // 30 load lone mvi
    tbl.push_back(v(0,0,0,9'h000,1,1,0, 1,9'h000,0,0,0,1,1,0));  // 31 start len1
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h058,1,1,0,0,0,0));  // 32 issue truncated mvi
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,0,0,1,1,0));  // 33 error
    tbl.push_back(v(0,1,0,9'h0C1,0,0,0, 1,9'h000,0,0,0,1,1,0));  // 34 load sub
    tbl.push_back(v(0,0,0,9'h000,1,1,0, 1,9'h000,0,0,0,1,1,0));  // 35 start len1
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h0C1,1,1,0,0,0,0));  // 36 issue
    tbl.push_back(v(0,1,0,9'h1FF,5,1,0, 1,9'h000,0,1,0,0,1,0));  // 37 load+start while busy
    tbl.push_back(v(0,0,0,9'h000,0,0,1, 1,9'h000,0,1,0,0,1,0));  // 38 no restart, Done
    tbl.push_back(v(0,0,0,9'h000,1,1,0, 1,9'h000,0,0,1,0,1,1));  // 39 halted, restart
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h0C1,1,1,0,0,0,0));  // 40 RAM[0] intact
    tbl.push_back(v(1,0,0,9'h000,0,0,0, 1,9'h000,0,1,0,0,1,0));  // 41 reset mid-wait
    tbl.push_back(v(0,0,0,9'h000,0,1,0, 1,9'h000,0,0,0,0,0,0));  // 42 reset values, start len0
    tbl.push_back(v(0,1,0,9'h00A,1,1,0, 1,9'h000,0,0,1,0,0,0));  // 43 empty prog halts; load+start
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h00A,1,1,0,0,0,0));  // 44 same-cycle write fetched
    tbl.push_back(v(0,0,0,9'h000,0,0,1, 1,9'h000,0,1,0,0,1,0));  // 45 wait Done
    tbl.push_back(v(0,0,0,9'h000,0,0,0, 1,9'h000,0,0,1,0,1,1));  // 46 halted

    foreach (tbl[i]) begin
      @(negedge Clock);
      Reset = tbl[i].rst; LoadEn = tbl[i].ld; LoadAddr = tbl[i].la;
      LoadData = tbl[i].ldd; ProgLen = tbl[i].plen; Start = tbl[i].st;
      Done = tbl[i].dn;
      if (i == 1) mon_en = 1'b1;
      if (tbl[i].chk) begin
        n_chk++;
        if ({DIN, Run, Busy, Halted, Err, PC, InstrCount} !==
            {tbl[i].din, tbl[i].run, tbl[i].busy, tbl[i].halt, tbl[i].err, tbl[i].pc, tbl[i].cnt}) begin
          n_err++;
          $display("FAIL vec%0d got DIN=%h Run=%b Busy=%b Halted=%b Err=%b PC=%0d Cnt=%0d required DIN=%h Run=%b Busy=%b Halted=%b Err=%b PC=%0d Cnt=%0d",
                   i, DIN, Run, Busy, Halted, Err, PC, InstrCount,
                   tbl[i].din, tbl[i].run, tbl[i].busy, tbl[i].halt, tbl[i].err, tbl[i].pc, tbl[i].cnt);
        end
      end
    end

    // Full-depth program: 32 mv words, ProgLen = 2^ADDR_W, Done one cycle after Run.
    for (int a = 0; a < 32; a++) begin
      @(negedge Clock);
      Reset = 0; Start = 0; Done = 0;
      LoadEn = 1; LoadAddr = 5'(a); LoadData = {3'b000, 6'(a)};
    end
    @(negedge Clock);
    LoadEn = 0; ProgLen = 6'd32; Start = 1;
    @(negedge Clock);
    Start = 0;
    run_seen = 0; runs = 0; reached = 0;
    for (int c = 0; c < 300 && !reached; c++) begin
      Done = run_seen;
      run_seen = Run;
      if (Halted) begin
        reached = 1;
      end else if (Run) begin
        exp_word = {3'b000, 6'(runs)};
        n_chk++;
        if (DIN !== exp_word) begin
          n_err++;
          $display("FAIL full_din run%0d got %h required %h", runs, DIN, exp_word);
        end
        runs++;
      end
      @(negedge Clock);
    end
    Done = 0;
    n_chk++;
    if (!reached) begin
      n_err++;
      $display("FAIL full_halt got no Halted within 300 cycles required Halted=1");
    end
    n_chk++;
    if (runs != 32) begin
      n_err++;
      $display("FAIL full_runs got %0d required 32", runs);
    end
    n_chk++;
    if ({PC, InstrCount, Err, Busy} !== {6'd32, 8'd32, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL full_final got PC=%0d Cnt=%0d Err=%b Busy=%b required PC=32 Cnt=32 Err=0 Busy=0",
               PC, InstrCount, Err, Busy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
